// File: rtl/p_pkg.sv
// Shared types and helpers for the unary (thermometer) encoder.
package p_pkg;

  localparam int ERR_CNT_W = 8;
  localparam int THERM_MAX_W = 64;

  typedef logic [ERR_CNT_W-1:0] err_cnt_t;

  typedef struct packed {
    logic inv;
    logic [THERM_MAX_W-1:0] code;
  } p_req_t;

  function automatic logic [THERM_MAX_W-1:0] p_therm(
    input int w,
    input int n
  );
    logic [THERM_MAX_W-1:0] r;
    for (int i = 0; i < THERM_MAX_W; i++) begin
      r[i] = (i < n) && (i < w);
    end
    return r;
  endfunction

endpackage

// File: rtl/p_enc_skid.sv
// Two-entry valid/ready buffer: output register plus skid register.
module p_enc_skid
  import p_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  input  logic [DW-1:0] i_data,
  output logic          o_rdy,
  output logic          o_vld,
  output logic [DW-1:0] o_data,
  input  logic          i_rdy
);

  logic          or_vld_q, or_vld_d;
  logic [DW-1:0] or_data_q, or_data_d;
  logic          sk_vld_q, sk_vld_d;
  logic [DW-1:0] sk_data_q, sk_data_d;
  logic          or_free;
  logic          acc;

  assign o_rdy   = ~sk_vld_q & ~rst;
  assign o_vld   = or_vld_q;
  assign o_data  = or_data_q;
  assign or_free = ~or_vld_q | i_rdy;
  assign acc     = i_vld & o_rdy;

  always_comb begin
    or_vld_d  = or_vld_q;
    or_data_d = or_data_q;
    sk_vld_d  = sk_vld_q;
    sk_data_d = sk_data_q;
    if (or_free) begin
      if (sk_vld_q) begin
        or_vld_d  = 1'b1;
        or_data_d = sk_data_q;
        sk_vld_d  = 1'b0;
      end else begin
        or_vld_d = acc;
        if (acc) or_data_d = i_data;
      end
    end else if (acc) begin
      // OR stalled: o_rdy guarantees SK is free here
      sk_vld_d  = 1'b1;
      sk_data_d = i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      or_vld_q  <= 1'b0;
      or_data_q <= '0;
      sk_vld_q  <= 1'b0;
      sk_data_q <= '0;
    end else begin
      or_vld_q  <= or_vld_d;
      or_data_q <= or_data_d;
      sk_vld_q  <= sk_vld_d;
      sk_data_q <= sk_data_d;
    end
  end

endmodule

// File: rtl/p_enc.sv
// Streaming binary-to-thermometer encoder with range check,
// optional complement and saturating drop counter.
module p_enc
  import p_pkg::*;
#(
  parameter int W = 16,
  parameter bit P_ADMIT_COMPLIMENT_EN = 1'b1,
  localparam int N_W = $clog2(W) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_vld,
  input  logic [N_W-1:0]       i_n,
  input  logic                 i_inv,
  output logic                 o_rdy,
  output logic                 o_vld,
  output logic [W-1:0]         o_x,
  input  logic                 i_rdy,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam logic [N_W-1:0] W_N = N_W'(W);

  p_req_t   req;
  logic     in_rng;
  logic     inv_eff;
  logic     acc;
  logic [W-1:0] code;
  logic     unused_hi;
  logic     err_q, err_d;
  err_cnt_t err_cnt_q, err_cnt_d;

  assign in_rng    = i_n < W_N;
  assign inv_eff   = i_inv & P_ADMIT_COMPLIMENT_EN;
  assign req.inv   = inv_eff;
  assign req.code  = p_therm(W, int'(i_n));
  assign unused_hi = ^req.code[THERM_MAX_W-1:W];
  assign code      = req.inv ? ~req.code[W-1:0] : req.code[W-1:0];
  assign acc       = i_vld & o_rdy;

  p_enc_skid #(
    .DW(W)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .i_vld (i_vld & in_rng),
    .i_data(code),
    .o_rdy (o_rdy),
    .o_vld (o_vld),
    .o_data(o_x),
    .i_rdy (i_rdy)
  );

  always_comb begin
    err_d     = acc & ~in_rng;
    err_cnt_d = err_cnt_q;
    if (err_d && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_err     = err_q;
  assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_p_enc.sv
// Directed self-checking bench for p_enc (W=16, both
// complement settings).
module tb_p_enc;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_vld;
  logic [4:0]  i_n;
  logic        i_inv;
  logic        i_rdy;

  logic        o_rdy, o_vld, o_err;
  logic [15:0] o_x;
  logic [7:0]  o_err_cnt;
  logic        o_rdy0, o_vld0, o_err0;
  logic [15:0] o_x0;
  logic [7:0]  o_err_cnt0;

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  p_enc #(.W(16), .P_ADMIT_COMPLIMENT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_n(i_n),
    .i_inv(i_inv), .o_rdy(o_rdy), .o_vld(o_vld),
    .o_x(o_x), .i_rdy(i_rdy), .o_err(o_err),
    .o_err_cnt(o_err_cnt)
  );

  p_enc #(.W(16), .P_ADMIT_COMPLIMENT_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_n(i_n),
    .i_inv(i_inv), .o_rdy(o_rdy0), .o_vld(o_vld0),
    .o_x(o_x0), .i_rdy(i_rdy), .o_err(o_err0),
    .o_err_cnt(o_err_cnt0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] n,
                       input logic inv);
    i_vld = v;
    i_n   = n;
    i_inv = inv;
  endtask

  initial begin
    rst = 1'b1;
    i_rdy = 1'b1;
    drive(1'b0, 5'd0, 1'b0);
    tick(); tick();
    chk("rst_vld", {31'd0, o_vld}, 32'd0);
    chk("rst_cnt", {24'd0, o_err_cnt}, 32'd0);
    chk("rst_rdy", {31'd0, o_rdy}, 32'd0);
    chk("rst_x", {16'd0, o_x}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", {31'd0, o_rdy}, 32'd1);

    // streaming, no complement
    drive(1'b1, 5'd0, 1'b0); tick();
    chk("s0_vld", {31'd0, o_vld}, 32'd1);
    chk("s0_x", {16'd0, o_x}, 32'h0000);
    drive(1'b1, 5'd1, 1'b0); tick();
    chk("s1_x", {16'd0, o_x}, 32'h0001);
    drive(1'b1, 5'd5, 1'b0); tick();
    chk("s5_x", {16'd0, o_x}, 32'h001F);
    drive(1'b1, 5'd15, 1'b0); tick();
    chk("s15_x", {16'd0, o_x}, 32'h7FFF);
    chk("s15_vld", {31'd0, o_vld}, 32'd1);
    drive(1'b0, 5'd0, 1'b0); tick();
    chk("s_idle", {31'd0, o_vld}, 32'd0);

    // complement enabled vs disabled
    drive(1'b1, 5'd3, 1'b1); tick();
    chk("inv3_x", {16'd0, o_x}, 32'hFFF8);
    chk("inv3_x_dis", {16'd0, o_x0}, 32'h0007);
    drive(1'b1, 5'd15, 1'b1); tick();
    chk("inv15_x", {16'd0, o_x}, 32'h8000);
    chk("inv15_x_dis", {16'd0, o_x0}, 32'h7FFF);
    drive(1'b0, 5'd0, 1'b0); tick();

    // backpressure
    i_rdy = 1'b0;
    drive(1'b1, 5'd1, 1'b0); tick();
    chk("bp1_x", {16'd0, o_x}, 32'h0001);
    chk("bp1_rdy", {31'd0, o_rdy}, 32'd1);
    drive(1'b1, 5'd2, 1'b0); tick();
    chk("bp2_rdy", {31'd0, o_rdy}, 32'd0);
    chk("bp2_x", {16'd0, o_x}, 32'h0001);
    drive(1'b1, 5'd3, 1'b0); tick();
    chk("bp_hold_x", {16'd0, o_x}, 32'h0001);
    chk("bp_hold_vld", {31'd0, o_vld}, 32'd1);
    i_rdy = 1'b1;
    tick();
    chk("bp_rel2_x", {16'd0, o_x}, 32'h0003);
    chk("bp_rel2_rdy", {31'd0, o_rdy}, 32'd1);
    tick();
    chk("bp_rel3_x", {16'd0, o_x}, 32'h0007);
    drive(1'b0, 5'd0, 1'b0); tick();
    chk("bp_drain", {31'd0, o_vld}, 32'd0);

    // out-of-range drops
    drive(1'b1, 5'd16, 1'b0); tick();
    chk("oor16_err", {31'd0, o_err}, 32'd1);
    chk("oor16_vld", {31'd0, o_vld}, 32'd0);
    chk("oor16_cnt", {24'd0, o_err_cnt}, 32'd1);
    drive(1'b1, 5'd31, 1'b0); tick();
    chk("oor31_err", {31'd0, o_err}, 32'd1);
    chk("oor31_vld", {31'd0, o_vld}, 32'd0);
    drive(1'b1, 5'd2, 1'b0); tick();
    chk("oor_ok_err", {31'd0, o_err}, 32'd0);
    chk("oor_ok_x", {16'd0, o_x}, 32'h0003);
    chk("oor_ok_vld", {31'd0, o_vld}, 32'd1);
    chk("oor_cnt2", {24'd0, o_err_cnt}, 32'd2);
    drive(1'b0, 5'd0, 1'b0); tick();
    chk("oor_idle", {31'd0, o_vld}, 32'd0);

    // saturation
    drive(1'b1, 5'd20, 1'b0);
    for (int k = 0; k < 300; k++) tick();
    drive(1'b0, 5'd0, 1'b0); tick();
    chk("sat_cnt", {24'd0, o_err_cnt}, 32'd255);
    chk("sat_vld", {31'd0, o_vld}, 32'd0);
    chk("sat_rdy", {31'd0, o_rdy}, 32'd1);

    // reset with OR and SK full
    i_rdy = 1'b0;
    drive(1'b1, 5'd4, 1'b0); tick();
    drive(1'b1, 5'd5, 1'b0); tick();
    chk("full_vld", {31'd0, o_vld}, 32'd1);
    chk("full_rdy", {31'd0, o_rdy}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_vld", {31'd0, o_vld}, 32'd0);
    chk("mrst_x", {16'd0, o_x}, 32'h0000);
    chk("mrst_cnt", {24'd0, o_err_cnt}, 32'd0);
    drive(1'b0, 5'd0, 1'b0);
    tick();
    rst = 1'b0;
    i_rdy = 1'b1;
    tick();
    chk("mrst_stale1", {31'd0, o_vld}, 32'd0);
    tick();
    chk("mrst_stale2", {31'd0, o_vld}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
